// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes
// and datapath select codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Extender format for an opcode; unknown opcodes fall back to I-format.
    function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU decoder: fixed add/sub from the FSM, or a funct3/funct7
// decode for register and immediate ALU instructions.
module alu_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] aluControl
);

    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            ALUOP_SUB: aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  aluControl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluControl = ALU_SLT;
                    3'b110:  aluControl = ALU_OR;
                    3'b111:  aluControl = ALU_AND;
                    default: aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core (lw, sw, R/I ALU, beq, jal).
// Define ILLEGAL_TRAP_EN to trap unknown opcodes into a HALT state.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [1:0]         immSrc,
    output logic [1:0]         aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         resultSrc,
    output logic [2:0]         aluControl,
    output logic               adrSrc,
    output logic               irWrite,
    output logic               pcWrite,
    output logic               regWrite,
    output logic               memWrite,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    state_t     state_q, state_d;
    logic       boot_q;
    logic       wr_ok;
    logic [1:0] alu_op;
    logic       ir_we, pc_we, reg_we, mem_we;

    // boot_q covers the first cycle after reset release: nothing is written
    // and FETCH does not advance until the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            boot_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            boot_q  <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready && !boot_q) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = S_HALT;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore selects per state; FETCH values double as the idle defaults.
    always_comb begin
        adrSrc    = 1'b0;
        aluSrcA   = SRCA_PC;
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALU;
        alu_op    = ALUOP_ADD;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_we = mem_ready;
                pc_we = mem_ready;
            end
            S_DECODE: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                adrSrc    = 1'b1;
                resultSrc = RES_ALUOUT;
            end
            S_MEMWB: begin
                resultSrc = RES_MEMDATA;
                reg_we    = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc    = 1'b1;
                resultSrc = RES_ALUOUT;
                mem_we    = 1'b1;
            end
            S_EXECUTER: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_RS2;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                resultSrc = RES_ALUOUT;
                reg_we    = 1'b1;
            end
            S_BEQ: begin
                aluSrcA   = SRCA_RS1;
                aluSrcB   = SRCB_RS2;
                alu_op    = ALUOP_SUB;
                resultSrc = RES_ALUOUT;
                pc_we     = zero;
            end
            S_JAL: begin
                aluSrcA   = SRCA_OLDPC;
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALUOUT;
                pc_we     = 1'b1;
            end
            default: ;
        endcase
    end

    alu_dec u_alu_dec (
        .aluOp      (alu_op),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .aluControl (aluControl)
    );

    // Reset is asynchronous, so write enables are also masked combinationally.
    assign wr_ok    = !reset && !boot_q;
    assign irWrite  = ir_we  && wr_ok;
    assign pcWrite  = pc_we  && wr_ok;
    assign regWrite = reg_we && wr_ok;
    assign memWrite = mem_we && wr_ok;
    assign immSrc   = imm_src_of(op);
    assign state    = STATE_W'(state_q);

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (state_q == S_HALT) && !reset;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core. It sequences fetch, decode, execute, memory and writeback, one instruction at a time.
- Drives the immediate-format select into the instruction decoder/extender, plus all datapath mux selects and write enables.
- Stalls on a memory-ready handshake from the unified instruction/data memory.
- Supported subset: lw, sw, R-type ALU, I-type ALU, beq, jal.

Parameters:
- STATE_W, 4, width of state register and debug state output.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  7  instruction[6:0] from instruction register.
- funct3  in  3  instruction[14:12].
- funct7b5  in  1  instruction[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the current read/write this cycle.
- immSrc  out  2  extender format select: 00 I, 01 S, 10 B, 11 J.
- aluSrcA  out  2  00 PC, 01 oldPC, 10 rs1 data.
- aluSrcB  out  2  00 rs2 data, 01 immext, 10 constant 4.
- resultSrc  out  2  00 ALUOut, 01 memory data, 10 ALU result.
- aluControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- adrSrc  out  1  memory address: 0 PC, 1 result.
- irWrite  out  1  load instruction register (and oldPC).
- pcWrite  out  1  load PC.
- regWrite  out  1  register file write.
- memWrite  out  1  memory write request.
- illegal  out  1  illegal-opcode flag (only with ILLEGAL_TRAP_EN; tied 0 otherwise).
- state  out  STATE_W  current state, for debug and the bench.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset state: while reset is high, state = FETCH (0).
  - irWrite, pcWrite, regWrite and memWrite are forced to 0; illegal = 0.
  - Selects take their FETCH values.
- Output style: Moore selects decoded from state. pcWrite and irWrite additionally gate on mem_ready, zero and branch, as listed per state.
- Encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, HALT 11.
- FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, add, resultSrc=10.
  - irWrite = pcWrite = mem_ready.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: aluSrcA=01, aluSrcB=01, add (branch/jump target into ALUOut). immSrc is driven from op. Next state by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECUTER.
  - 0010011 -> EXECUTEI.
  - 1100011 -> BEQ.
  - 1101111 -> JAL.
  - any other op -> FETCH (or HALT with the optional feature).
- MEMADR: aluSrcA=10, aluSrcB=01, add. Next state: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adrSrc=1, resultSrc=00. Hold until mem_ready, then go to MEMWB.
- MEMWB: resultSrc=01, regWrite=1, then FETCH.
- MEMWRITE: adrSrc=1, resultSrc=00, memWrite=1.
  - memWrite is held high every cycle until mem_ready, then go to FETCH.
  - memWrite drops to 0 in the cycle after acceptance.
- EXECUTER: aluSrcA=10, aluSrcB=00, ALU decode applies; then ALUWB.
- EXECUTEI: aluSrcA=10, aluSrcB=01, ALU decode applies; then ALUWB.
- ALUWB: resultSrc=00, regWrite=1, then FETCH.
- BEQ: aluSrcA=10, aluSrcB=00, sub, resultSrc=00, pcWrite=zero; then FETCH.
- JAL: aluSrcA=01, aluSrcB=10, add, resultSrc=00, pcWrite=1; then ALUWB (writes PC+4 to rd).
- immSrc by opcode:
  - lw and I-ALU -> 00.
  - sw -> 01.
  - beq -> 10.
  - jal -> 11.
  - others -> 00.
  - immSrc is valid in every state, not only DECODE.
- ALU decode (EXECUTER/EXECUTEI only), by funct3:
  - 000: sub iff op[5]=1 and funct7b5=1, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - other: add.
- Other states: aluControl is fixed as listed per state.
- Boundary conditions:
  - A mem_ready pulse while outside FETCH, MEMREAD or MEMWRITE is ignored.
  - Reset asserted mid-instruction aborts it immediately. No write enable may be high during reset or on the first cycle after release.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- With the macro defined:
  - An unrecognised op in DECODE goes to HALT.
  - HALT asserts illegal=1 with all write enables 0, and is exited only by reset.
- Without the macro: an unrecognised op returns to FETCH as a no-op (PC already advanced), and illegal is tied 0.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state encodings;
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - immSrc, aluSrcA/B, resultSrc and aluControl codes.
- One sub-module, alu_dec: a combinational ALU decoder with inputs aluOp[1:0], funct3, op[5], funct7b5 and output aluControl. The FSM drives aluOp: 00 add, 01 sub, 10 funct-decode.

Test Plan:
- Reset mid-MEMWRITE with memWrite=1 -> state=0 and all enables 0 immediately (asynchronously). After release, FETCH with irWrite=0 until mem_ready.
- lw (op 0000011), mem_ready low 3 cycles in both FETCH and MEMREAD -> state sequence 0,0,0,0,1,2,3,3,3,3,4,0; regWrite=1 only in state 4.
- sw with mem_ready low 2 cycles -> memWrite held 3 cycles, immSrc=01 in DECODE, then FETCH.
- R-type sub (funct3=000, funct7b5=1) -> aluControl=001 in EXECUTER. addi with funct7b5=1 -> aluControl=000.
- beq with zero=1 -> pcWrite=1 in BEQ; with zero=0 -> pcWrite=0. immSrc=10 in both cases.
- op 1111111 -> returns to FETCH (macro off), or enters HALT with illegal=1 held for 10 cycles (macro on).
